// File: rtl/bus_ram_ctrl.sv
// bus_ram_ctrl: req/ready RAM on a tri-state bus with wait states, a read buffer and an auto-increment pointer
module bus_ram_ctrl #(
  parameter int    DATA_WIDTH  = 8,
  parameter int    ADDR_WIDTH  = 8,
  parameter int    WAIT_STATES = 0,
  parameter string INIT_FILE   = "memory.list"
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  req,
  input  logic                  we,
  input  logic                  oe,
  input  logic                  use_ptr,
  input  logic                  ptr_ld,
  inout  wire  [DATA_WIDTH-1:0] data,
  output logic                  ready,
  output logic                  rd_valid,
  output logic [ADDR_WIDTH-1:0] ptr
);
  typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;
  localparam logic [3:0] WS_LAST = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rbuf_q, rbuf_d;
  logic we_q, we_d, rd_valid_q, rd_valid_d, accept;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  always_comb begin
    accept = state_q == IDLE && req;
    state_d = accept ? (WAIT_STATES > 0 ? WAIT : ACCESS) : state_q == WAIT ? (cnt_q == WS_LAST ? ACCESS : WAIT) : IDLE;
    cnt_d = state_q == WAIT && cnt_q != WS_LAST ? cnt_q + 4'd1 : 4'd0;
    addr_d = accept ? (use_ptr && !ptr_ld ? ptr_q : addr) : addr_q;
    we_d = accept ? we : we_q;
    wdata_d = accept ? data : wdata_q;
    ptr_d = (ptr_ld ? addr : ptr_q) + ADDR_WIDTH'(accept && use_ptr);
    rd_valid_d = state_q == ACCESS && !we_q;
    rbuf_d = rd_valid_d ? mem[addr_q] : rbuf_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      ptr_q <= '0;
      wdata_q <= '0;
      rbuf_q <= '0;
      we_q <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      ptr_q <= ptr_d;
      wdata_q <= wdata_d;
      rbuf_q <= rbuf_d;
      we_q <= we_d;
      rd_valid_q <= rd_valid_d;
    end
  always_ff @(posedge clk)
    if (state_q == ACCESS && we_q) mem[addr_q] <= wdata_q;
  assign ready = state_q == IDLE;
  assign rd_valid = rd_valid_q;
  assign ptr = ptr_q;
  assign data = oe && !we ? rbuf_q : 'z;
endmodule

// File: tb/tb_bus_ram_ctrl.sv
// tb_bus_ram_ctrl: directed self-checking bench for bus_ram_ctrl with 0, 2 and 3 wait states
module tb_bus_ram_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] addr = '0, tb_d = '0;
  logic req0 = 1'b0, req2 = 1'b0, req3 = 1'b0;
  logic we = 1'b0, oe = 1'b1, use_ptr = 1'b0, ptr_ld = 1'b0, tb_en = 1'b0;
  wire [7:0] data0, data2, data3;
  logic ready0, ready2, ready3, rd_valid0, rd_valid2, rd_valid3;
  logic [7:0] ptr0, ptr2, ptr3;
  int errs = 0, checks = 0;
  assign data0 = tb_en ? tb_d : 'z;
  assign data2 = tb_en ? tb_d : 'z;
  assign data3 = tb_en ? tb_d : 'z;
  always #5 clk = ~clk;
  bus_ram_ctrl #(.WAIT_STATES(0), .INIT_FILE("")) u0 (.clk(clk), .rst_n(rst_n), .addr(addr), .req(req0), .we(we), .oe(oe), .use_ptr(use_ptr), .ptr_ld(ptr_ld), .data(data0), .ready(ready0), .rd_valid(rd_valid0), .ptr(ptr0));
  bus_ram_ctrl #(.WAIT_STATES(2), .INIT_FILE("")) u2 (.clk(clk), .rst_n(rst_n), .addr(addr), .req(req2), .we(we), .oe(oe), .use_ptr(use_ptr), .ptr_ld(ptr_ld), .data(data2), .ready(ready2), .rd_valid(rd_valid2), .ptr(ptr2));
  bus_ram_ctrl #(.WAIT_STATES(3), .INIT_FILE("")) u3 (.clk(clk), .rst_n(rst_n), .addr(addr), .req(req3), .we(we), .oe(oe), .use_ptr(use_ptr), .ptr_ld(ptr_ld), .data(data3), .ready(ready3), .rd_valid(rd_valid3), .ptr(ptr3));
  task automatic xfer(input int k, input logic w, input logic [7:0] a, input logic [7:0] d, input logic up, input int n);
    addr = a;
    we = w;
    use_ptr = up;
    if (w) begin
      tb_d = d;
      tb_en = 1'b1;
    end
    req0 = k == 0;
    req2 = k == 2;
    req3 = k == 3;
    @(negedge clk);
    req0 = 1'b0;
    req2 = 1'b0;
    req3 = 1'b0;
    use_ptr = 1'b0;
    repeat (n) @(negedge clk);
    if (w) tb_en = 1'b0;
    we = 1'b0;
  endtask
  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++; if (ready0 !== 1'b1) begin errs++; $display("FAIL reset_ready0: got %b want 1", ready0); end
    checks++; if (ready3 !== 1'b1) begin errs++; $display("FAIL reset_ready3: got %b want 1", ready3); end
    checks++; if (rd_valid0 !== 1'b0) begin errs++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid0); end
    checks++; if (ptr0 !== 8'h00) begin errs++; $display("FAIL reset_ptr: got %h want 00", ptr0); end
    checks++; if (data0 !== 8'h00) begin errs++; $display("FAIL reset_buffer: got %h want 00", data0); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_read;
    xfer(0, 1'b1, 8'h10, 8'hA5, 1'b0, 1);
    xfer(0, 1'b0, 8'h10, 8'h00, 1'b0, 0);
    checks++; if (ready0 !== 1'b0) begin errs++; $display("FAIL rd_busy: got %b want 0", ready0); end
    checks++; if (rd_valid0 !== 1'b0) begin errs++; $display("FAIL rd_valid_early: got %b want 0", rd_valid0); end
    @(negedge clk);
    checks++; if (ready0 !== 1'b1) begin errs++; $display("FAIL rd_ready_back: got %b want 1", ready0); end
    checks++; if (rd_valid0 !== 1'b1) begin errs++; $display("FAIL rd_valid_pulse: got %b want 1", rd_valid0); end
    checks++; if (data0 !== 8'hA5) begin errs++; $display("FAIL rd_data: got %h want a5", data0); end
    @(negedge clk);
    checks++; if (rd_valid0 !== 1'b0) begin errs++; $display("FAIL rd_valid_end: got %b want 0", rd_valid0); end
    checks++; if (data0 !== 8'hA5) begin errs++; $display("FAIL rd_data_hold: got %h want a5", data0); end
  endtask
  task automatic test_write;
    addr = 8'h20;
    we = 1'b1;
    tb_d = 8'h3C;
    tb_en = 1'b1;
    req0 = 1'b1;
    #1;
    checks++; if (data0 !== 8'h3C) begin errs++; $display("FAIL wr_bus_hiz: got %h want 3c", data0); end
    @(negedge clk);
    req0 = 1'b0;
    tb_d = 8'hFF;
    @(negedge clk);
    tb_en = 1'b0;
    we = 1'b0;
    xfer(0, 1'b0, 8'h20, 8'h00, 1'b0, 1);
    checks++; if (rd_valid0 !== 1'b1) begin errs++; $display("FAIL wr_rd_valid: got %b want 1", rd_valid0); end
    checks++; if (data0 !== 8'h3C) begin errs++; $display("FAIL wr_readback: got %h want 3c", data0); end
  endtask
  task automatic test_wait_states;
    int busy = 0, pulses = 0;
    xfer(3, 1'b1, 8'h05, 8'h77, 1'b0, 4);
    checks++; if (ready3 !== 1'b1) begin errs++; $display("FAIL ws_wr_done: got %b want 1", ready3); end
    xfer(3, 1'b0, 8'h05, 8'h00, 1'b0, 0);
    for (int i = 0; i < 10; i++) begin
      if (!ready3) busy++;
      if (rd_valid3) pulses++;
      req3 = i == 1;
      use_ptr = i == 1;
      @(negedge clk);
    end
    req3 = 1'b0;
    use_ptr = 1'b0;
    checks++; if (busy != 4) begin errs++; $display("FAIL ws_busy_cycles: got %0d want 4", busy); end
    checks++; if (pulses != 1) begin errs++; $display("FAIL ws_rd_pulses: got %0d want 1", pulses); end
    checks++; if (ptr3 !== 8'h00) begin errs++; $display("FAIL ws_ptr_unmoved: got %h want 00", ptr3); end
    checks++; if (data3 !== 8'h77) begin errs++; $display("FAIL ws_rd_data: got %h want 77", data3); end
  endtask
  task automatic test_pointer;
    logic [7:0] ra [4] = '{8'hFE, 8'hFF, 8'h00, 8'h40};
    logic [7:0] rv [4] = '{8'h01, 8'h02, 8'h03, 8'h99};
    addr = 8'hFE;
    ptr_ld = 1'b1;
    @(negedge clk);
    ptr_ld = 1'b0;
    checks++; if (ptr0 !== 8'hFE) begin errs++; $display("FAIL ptr_load: got %h want fe", ptr0); end
    for (int i = 0; i < 3; i++) xfer(0, 1'b1, 8'h00, 8'(i + 1), 1'b1, 1);
    checks++; if (ptr0 !== 8'h01) begin errs++; $display("FAIL ptr_wrap: got %h want 01", ptr0); end
    addr = 8'h40;
    we = 1'b1;
    tb_d = 8'h99;
    tb_en = 1'b1;
    use_ptr = 1'b1;
    ptr_ld = 1'b1;
    req0 = 1'b1;
    @(negedge clk);
    req0 = 1'b0;
    ptr_ld = 1'b0;
    use_ptr = 1'b0;
    checks++; if (ptr0 !== 8'h41) begin errs++; $display("FAIL ptr_ld_with_req: got %h want 41", ptr0); end
    @(negedge clk);
    tb_en = 1'b0;
    we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      xfer(0, 1'b0, ra[i], 8'h00, 1'b0, 1);
      checks++; if (data0 !== rv[i]) begin errs++; $display("FAIL ptr_readback[%h]: got %h want %h", ra[i], data0, rv[i]); end
    end
  endtask
  task automatic test_reset_mid_access;
    addr = 8'h33;
    ptr_ld = 1'b1;
    @(negedge clk);
    ptr_ld = 1'b0;
    xfer(2, 1'b1, 8'h30, 8'h11, 1'b0, 3);
    xfer(2, 1'b0, 8'h30, 8'h00, 1'b0, 3);
    checks++; if (data2 !== 8'h11) begin errs++; $display("FAIL rm_setup: got %h want 11", data2); end
    xfer(2, 1'b1, 8'h30, 8'h22, 1'b0, 0);
    tb_en = 1'b0;
    we = 1'b0;
    checks++; if (ready2 !== 1'b0) begin errs++; $display("FAIL rm_busy: got %b want 0", ready2); end
    rst_n = 1'b0;
    #1;
    checks++; if (ready2 !== 1'b1) begin errs++; $display("FAIL rm_ready_async: got %b want 1", ready2); end
    checks++; if (ptr2 !== 8'h00) begin errs++; $display("FAIL rm_ptr: got %h want 00", ptr2); end
    checks++; if (data2 !== 8'h00) begin errs++; $display("FAIL rm_buffer: got %h want 00", data2); end
    checks++; if (rd_valid2 !== 1'b0) begin errs++; $display("FAIL rm_rd_valid: got %b want 0", rd_valid2); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    xfer(2, 1'b0, 8'h30, 8'h00, 1'b0, 3);
    checks++; if (rd_valid2 !== 1'b1) begin errs++; $display("FAIL rm_rd_valid_after: got %b want 1", rd_valid2); end
    checks++; if (data2 !== 8'h11) begin errs++; $display("FAIL rm_write_dropped: got %h want 11", data2); end
  endtask
  task automatic test_output_enable;
    oe = 1'b0;
    tb_d = 8'h00;
    tb_en = 1'b1;
    xfer(0, 1'b0, 8'h20, 8'h00, 1'b0, 1);
    checks++; if (rd_valid0 !== 1'b1) begin errs++; $display("FAIL oe_rd_valid: got %b want 1", rd_valid0); end
    checks++; if (data0 !== 8'h00) begin errs++; $display("FAIL oe_low_hiz: got %h want 00", data0); end
    tb_en = 1'b0;
    @(negedge clk);
    oe = 1'b1;
    #1;
    checks++; if (data0 !== 8'h3C) begin errs++; $display("FAIL oe_late_data: got %h want 3c", data0); end
  endtask
  initial begin
    test_reset;
    test_read;
    test_write;
    test_wait_states;
    test_pointer;
    test_reset_mid_access;
    test_output_enable;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
